// File: rtl/alu_seq.sv
// alu_seq: registered ALU with start/busy/done handshake and a tri-state result bus.
// Optional ALU_MULDIV_EN builds the iterative multiply/divide/modulo path (opcodes 10-12).

module alu_seq #(
  parameter  int WIDTH = 16,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Rst,
  inout  wire [WIDTH-1:0]  Bus,
  input  logic [WIDTH-1:0] Reg1,
  input  logic [WIDTH-1:0] Reg2,
  input  logic [3:0]       Operation,
  input  logic             Start,
  input  logic             SumOut,
  output logic             Busy,
  output logic             Done,
  output logic [3:0]       Flags
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH:0] LP_WIDTH = (WIDTH+1)'(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_SHL = 4'd2,  OP_SHR = 4'd3;
  localparam logic [3:0] OP_LT  = 4'd4,  OP_GT  = 4'd5,  OP_XOR = 4'd6,  OP_NOT = 4'd7;
  localparam logic [3:0] OP_AND = 4'd8,  OP_OR  = 4'd9,  OP_MUL = 4'd10, OP_DIV = 4'd11;
  localparam logic [3:0] OP_MOD = 4'd12, OP_ADC = 4'd13, OP_ASR = 4'd14, OP_PSA = 4'd15;

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_ITER = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1} state_t;
`endif

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_result;
  logic [3:0]       r_op, r_flags;
  logic             r_done;

  logic [WIDTH-1:0] w_res;
  logic             w_c, w_v, w_big;
  logic [CW-1:0]    w_sh;
  logic [3:0]       w_exec_flags;

  assign Busy  = (r_state != S_IDLE);
  assign Done  = r_done;
  assign Flags = r_flags;
  assign Bus   = SumOut ? r_result : 'z;

  // Single-cycle datapath; also produces the divide-by-zero / illegal-op result.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_big = ({1'b0, r_b} >= LP_WIDTH);
    w_sh  = r_b[CW-1:0];
    case (r_op)
      OP_ADD: begin
        {w_c, w_res} = {1'b0, r_a} + {1'b0, r_b};
        w_v = (r_a[MSB] == r_b[MSB]) && (w_res[MSB] != r_a[MSB]);
      end
      OP_ADC: begin
        {w_c, w_res} = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_flags[1]};
        w_v = (r_a[MSB] == r_b[MSB]) && (w_res[MSB] != r_a[MSB]);
      end
      OP_SUB: begin
        w_res = r_a - r_b;
        w_c   = (r_a < r_b);
        w_v   = (r_a[MSB] != r_b[MSB]) && (w_res[MSB] != r_a[MSB]);
      end
      OP_SHL: w_res = w_big ? '0 : (r_a << w_sh);
      OP_SHR: w_res = w_big ? '0 : (r_a >> w_sh);
      OP_ASR: w_res = w_big ? {WIDTH{r_a[MSB]}} : $unsigned($signed(r_a) >>> w_sh);
      OP_LT:  w_res = WIDTH'(r_a < r_b);
      OP_GT:  w_res = WIDTH'(r_a > r_b);
      OP_XOR: w_res = r_a ^ r_b;
      OP_NOT: w_res = ~r_a;
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_PSA: w_res = r_a;
      default: begin
`ifdef ALU_MULDIV_EN
        // Only divide/modulo by zero reach EXEC with opcodes 10-12.
        w_res = '1;
        w_c   = 1'b1;
`else
        // Multiply/divide not built: flag as illegal op.
        w_res = '0;
        w_c   = 1'b1;
`endif
      end
    endcase
    w_exec_flags = {w_v, w_res[MSB], w_c, (w_res == '0)};
  end

`ifdef ALU_MULDIV_EN
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc, r_quo;
  logic [WIDTH-1:0] w_mul, w_rem_nx, w_quo_nx, w_iter_res;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge, w_iter_go;
  logic [3:0]       w_iter_flags;

  // MSB-first: multiply shifts the accumulator and adds A per B bit,
  // divide shifts in the next dividend bit and subtracts B when it fits.
  always_comb begin
    w_mul    = {r_acc[WIDTH-2:0], 1'b0} + (r_b[r_cnt] ? r_a : '0);
    w_rem_sh = {r_acc, r_a[r_cnt]};
    w_ge     = (w_rem_sh >= {1'b0, r_b});
    w_rem_nx = w_ge ? WIDTH'(w_rem_sh - {1'b0, r_b}) : w_rem_sh[WIDTH-1:0];
    w_quo_nx = r_quo | (WIDTH'(w_ge) << r_cnt);
    case (r_op)
      OP_MUL:  w_iter_res = w_mul;
      OP_DIV:  w_iter_res = w_quo_nx;
      default: w_iter_res = w_rem_nx;
    endcase
    w_iter_flags = {1'b0, w_iter_res[MSB], 1'b0, (w_iter_res == '0)};
  end

  assign w_iter_go = (Operation == OP_MUL) ||
                     (((Operation == OP_DIV) || (Operation == OP_MOD)) && (Reg2 != '0));
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
`ifdef ALU_MULDIV_EN
          w_next = w_iter_go ? S_ITER : S_EXEC;
`else
          w_next = S_EXEC;
`endif
        end
      end
      S_EXEC: w_next = S_IDLE;
`ifdef ALU_MULDIV_EN
      S_ITER: if (r_cnt == '0) w_next = S_IDLE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_flags  <= '0;
      r_done   <= 1'b0;
`ifdef ALU_MULDIV_EN
      r_cnt    <= '0;
      r_acc    <= '0;
      r_quo    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_a  <= Reg1;
            r_b  <= Reg2;
            r_op <= Operation;
`ifdef ALU_MULDIV_EN
            r_cnt <= CW'(WIDTH - 1);
            r_acc <= '0;
            r_quo <= '0;
`endif
          end
        end
        S_EXEC: begin
          r_result <= w_res;
          r_flags  <= w_exec_flags;
          r_done   <= 1'b1;
        end
`ifdef ALU_MULDIV_EN
        S_ITER: begin
          r_acc <= (r_op == OP_MUL) ? w_mul : w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            r_result <= w_iter_res;
            r_flags  <= w_iter_flags;
            r_done   <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table plus hand-written multi-cycle sequences,
// expected results queued at Start and compared when Done pulses.

module tb_alu_seq;

  localparam int W = 16;

  logic          Clk = 1'b0;
  logic          Rst;
  wire  [W-1:0]  Bus;
  logic [W-1:0]  Reg1, Reg2;
  logic [3:0]    Operation;
  logic          Start, SumOut, Busy, Done;
  logic [3:0]    Flags;
  logic          tb_en;

  // Bench pulls the bus to zero while the DUT should have released it.
  assign Bus = tb_en ? '0 : 'z;

  always #5 Clk = ~Clk;

  alu_seq #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Bus(Bus), .Reg1(Reg1), .Reg2(Reg2),
    .Operation(Operation), .Start(Start), .SumOut(SumOut),
    .Busy(Busy), .Done(Done), .Flags(Flags)
  );

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, res;
    logic [3:0]   fl;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   fl;
    int           lat;
    int           t0;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[$];
  vec_t v;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Expected latency and the illegal-op result depend on whether mul/div is built.
  function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] r, input logic [3:0] f);
    vec_t x;
    x.op = op; x.a = a; x.b = b; x.res = r; x.fl = f; x.lat = 1;
`ifdef ALU_MULDIV_EN
    if (op == 4'd10 || ((op == 4'd11 || op == 4'd12) && b != '0)) x.lat = W;
`else
    if (op inside {4'd10, 4'd11, 4'd12}) begin x.res = '0; x.fl = 4'b0011; end
`endif
    return x;
  endfunction

  always @(negedge Clk) begin
    if (!Rst && Done) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL extra_done: got Done=1 want no pending operation");
      end else begin
        mon_e = sb.pop_front();
        chk("result", Bus, mon_e.res);
        chk("flags", W'(Flags), W'(mon_e.fl));
        chk("latency", W'(cyc - mon_e.t0), W'(mon_e.lat));
        chk("busy_with_done", W'(Busy), W'(0));
      end
    end
  end

  // Drive at the current time (between edges), return #1 after the accepting edge.
  task automatic issue(input vec_t x);
    exp_t e;
    Reg1 = x.a; Reg2 = x.b; Operation = x.op; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    Reg1 = W'($urandom()); Reg2 = W'($urandom()); Operation = 4'($urandom());
    e.res = x.res; e.fl = x.fl; e.lat = x.lat; e.t0 = cyc;
    sb.push_back(e);
    chk("busy_after_start", W'(Busy), W'(1));
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge Clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL timeout: %0d ops still pending after %0d cycles", sb.size(), n);
      sb.delete();
    end
  endtask

  task automatic run(input vec_t x);
    @(negedge Clk);
    issue(x);
    wait_done();
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; SumOut = 1'b1; tb_en = 1'b0;
    Reg1 = '0; Reg2 = '0; Operation = '0;

    // Table order matters: adc rows depend on the Carry left by the row before.
    vecs.push_back(mk(4'd13, 16'h0000, 16'h0000, 16'h0000, 4'b0001));
    vecs.push_back(mk(4'd0,  16'hFFFF, 16'h0001, 16'h0000, 4'b0011));
    vecs.push_back(mk(4'd13, 16'h0000, 16'h0000, 16'h0001, 4'b0000));
    vecs.push_back(mk(4'd0,  16'h7FFF, 16'h0001, 16'h8000, 4'b1100));
    vecs.push_back(mk(4'd1,  16'h0001, 16'h0002, 16'hFFFF, 4'b0110));
    vecs.push_back(mk(4'd0,  16'h8000, 16'h8000, 16'h0000, 4'b1011));
    vecs.push_back(mk(4'd1,  16'h8000, 16'h0001, 16'h7FFF, 4'b1000));
    vecs.push_back(mk(4'd13, 16'h0001, 16'h0001, 16'h0002, 4'b0000));
    vecs.push_back(mk(4'd10, 16'd300,  16'd250,  16'h24F8, 4'b0000));
    vecs.push_back(mk(4'd10, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0000));
    vecs.push_back(mk(4'd10, 16'h1234, 16'h0000, 16'h0000, 4'b0001));
    vecs.push_back(mk(4'd11, 16'd100,  16'd7,    16'd14,   4'b0000));
    vecs.push_back(mk(4'd12, 16'd100,  16'd7,    16'd2,    4'b0000));
    vecs.push_back(mk(4'd11, 16'd7,    16'd100,  16'd0,    4'b0001));
    vecs.push_back(mk(4'd12, 16'd7,    16'd100,  16'd7,    4'b0000));
    vecs.push_back(mk(4'd11, 16'hFFFF, 16'h0001, 16'hFFFF, 4'b0100));
    vecs.push_back(mk(4'd12, 16'hFFFF, 16'h0001, 16'h0000, 4'b0001));
    vecs.push_back(mk(4'd11, 16'd5,    16'd0,    16'hFFFF, 4'b0110));
    vecs.push_back(mk(4'd12, 16'd5,    16'd0,    16'hFFFF, 4'b0110));
    vecs.push_back(mk(4'd2,  16'h0001, 16'd15,   16'h8000, 4'b0100));
    vecs.push_back(mk(4'd2,  16'h0001, 16'd16,   16'h0000, 4'b0001));
    vecs.push_back(mk(4'd3,  16'h8000, 16'd15,   16'h0001, 4'b0000));
    vecs.push_back(mk(4'd3,  16'h8000, 16'hFFFF, 16'h0000, 4'b0001));
    vecs.push_back(mk(4'd14, 16'h8000, 16'd4,    16'hF800, 4'b0100));
    vecs.push_back(mk(4'd14, 16'h8000, 16'd20,   16'hFFFF, 4'b0100));
    vecs.push_back(mk(4'd14, 16'h4000, 16'd2,    16'h1000, 4'b0000));
    vecs.push_back(mk(4'd4,  16'd3,    16'd5,    16'h0001, 4'b0000));
    vecs.push_back(mk(4'd5,  16'd3,    16'd5,    16'h0000, 4'b0001));
    vecs.push_back(mk(4'd6,  16'hF0F0, 16'hFF00, 16'h0FF0, 4'b0000));
    vecs.push_back(mk(4'd7,  16'h00FF, 16'h1234, 16'hFF00, 4'b0100));
    vecs.push_back(mk(4'd8,  16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000));
    vecs.push_back(mk(4'd9,  16'hF0F0, 16'h0FF0, 16'hFFF0, 4'b0100));
    vecs.push_back(mk(4'd15, 16'h1234, 16'hFFFF, 16'h1234, 4'b0000));

    repeat (2) @(negedge Clk);
    chk("rst_busy",  W'(Busy),  W'(0));
    chk("rst_done",  W'(Done),  W'(0));
    chk("rst_flags", W'(Flags), W'(0));
    chk("rst_bus",   Bus,       W'(0));
    Rst = 1'b0;

    foreach (vecs[i]) run(vecs[i]);

    // Back-to-back: adc issued in the Done cycle of an add sees the fresh Carry.
    @(negedge Clk);
    issue(mk(4'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b0011));
    @(posedge Clk); #1;
    chk("b2b_done_cycle", W'(Done), W'(1));
    issue(mk(4'd13, 16'h0000, 16'h0000, 16'h0001, 4'b0000));
    wait_done();

    // Bus gating: released with SumOut=0, result with SumOut=1.
    run(mk(4'd15, 16'h1234, 16'h0000, 16'h1234, 4'b0000));
    SumOut = 1'b0; tb_en = 1'b1; #1;
    chk("bus_released", Bus, W'(0));
    SumOut = 1'b1; tb_en = 1'b0; #1;
    chk("bus_driven", Bus, 16'h1234);

    // Start while busy is ignored; the bus keeps the previous result meanwhile.
    @(negedge Clk);
    issue(mk(4'd10, 16'd300, 16'd250, 16'h24F8, 4'b0000));
    chk("bus_during_busy", Bus, 16'h1234);
    Reg1 = 16'h0001; Reg2 = 16'h0001; Operation = 4'd0; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
`ifdef ALU_MULDIV_EN
    repeat (3) @(posedge Clk);
    #1 Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    chk("busy_mid_iter", W'(Busy), W'(1));
`endif
    wait_done();
    repeat (4) @(negedge Clk);
    chk("idle_after_ignored_start", W'(Busy), W'(0));

    // Reset in the middle of a multiply.
    @(negedge Clk);
    issue(mk(4'd10, 16'd300, 16'd250, 16'h24F8, 4'b0000));
    repeat (5) @(posedge Clk);
    #2 Rst = 1'b1;
    #1;
    chk("midrst_busy",  W'(Busy),  W'(0));
    chk("midrst_done",  W'(Done),  W'(0));
    chk("midrst_flags", W'(Flags), W'(0));
    chk("midrst_bus",   Bus,       W'(0));
    sb.delete();
    @(negedge Clk);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    chk("post_rst_busy", W'(Busy), W'(0));

    // Carry cleared by reset: adc 0+0 yields 0.
    run(mk(4'd13, 16'h0000, 16'h0000, 16'h0000, 4'b0001));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
